// File: rtl/spatial_position_integrator_if.sv
// Bundled tick/mode/data bus for spatial_position_integrator.
// Optional acceleration signals are present only when POS_ACCEL_EN is defined.
interface spatial_position_integrator_if #(
  parameter int unsigned AXES  = 3,
  parameter int unsigned POS_W = 16,
  parameter int unsigned VEL_W = 8
);
  logic                    tick;
  logic [2*AXES-1:0]       mode;
  logic [POS_W*AXES-1:0]   load_val;
  logic [VEL_W*AXES-1:0]   vel_in;
  logic [AXES-1:0]         vel_we;
  logic [AXES-1:0]         flag_clr;
`ifdef POS_ACCEL_EN
  logic [VEL_W*AXES-1:0]   accel_in;
  logic [AXES-1:0]         accel_en;
`endif
  logic [POS_W*AXES-1:0]   pos;
  logic [VEL_W*AXES-1:0]   vel;
  logic [AXES-1:0]         sat_flag;
  logic                    pos_valid;

`ifdef POS_ACCEL_EN
  modport master (
    output tick, mode, load_val, vel_in, vel_we, flag_clr, accel_in, accel_en,
    input  pos, vel, sat_flag, pos_valid
  );
  modport slave (
    input  tick, mode, load_val, vel_in, vel_we, flag_clr, accel_in, accel_en,
    output pos, vel, sat_flag, pos_valid
  );
`else
  modport master (
    output tick, mode, load_val, vel_in, vel_we, flag_clr,
    input  pos, vel, sat_flag, pos_valid
  );
  modport slave (
    input  tick, mode, load_val, vel_in, vel_we, flag_clr,
    output pos, vel, sat_flag, pos_valid
  );
`endif
endinterface

// File: rtl/spatial_position_integrator.sv
// N-axis saturating position integrator with latched velocities and sticky saturation flags.
// Define POS_ACCEL_EN to add per-axis saturating velocity acceleration on each tick.
module spatial_position_integrator #(
  parameter int unsigned AXES  = 3,
  parameter int unsigned POS_W = 16,
  parameter int unsigned VEL_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  spatial_position_integrator_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_INTEG = 2'b10,
    MODE_ZERO  = 2'b11
  } mode_e;

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic signed [POS_W-1:0] r_pos [AXES];
  logic signed [VEL_W-1:0] r_vel [AXES];
  logic [AXES-1:0]         r_sat;
  logic                    r_pos_valid;

  mode_e                   w_mode    [AXES];
  logic signed [POS_W:0]   w_psum    [AXES];
  logic signed [POS_W-1:0] w_pos_nxt [AXES];
  logic [AXES-1:0]         w_pos_ovf;
  logic [AXES-1:0]         w_sat_set;

`ifdef POS_ACCEL_EN
  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  logic signed [VEL_W:0]   w_vsum    [AXES];
  logic signed [VEL_W-1:0] w_vel_nxt [AXES];
  logic [AXES-1:0]         w_vel_ovf;
  logic [AXES-1:0]         w_acc_go;
`endif

  // Sums are formed one bit wider than the operand so overflow shows as a sign/MSB disagreement.
  always_comb begin
    w_pos_ovf = '0;
    w_sat_set = '0;
    for (int unsigned a = 0; a < AXES; a++) begin
      w_mode[a]    = mode_e'(bus.mode[2*a +: 2]);
      w_psum[a]    = {r_pos[a][POS_W-1], r_pos[a]}
                   + {{(POS_W+1-VEL_W){r_vel[a][VEL_W-1]}}, r_vel[a]};
      w_pos_nxt[a] = r_pos[a];
      case (w_mode[a])
        MODE_HOLD:  w_pos_nxt[a] = r_pos[a];
        MODE_LOAD:  w_pos_nxt[a] = bus.load_val[POS_W*a +: POS_W];
        MODE_INTEG: begin
          if (w_psum[a][POS_W] != w_psum[a][POS_W-1]) begin
            w_pos_ovf[a] = 1'b1;
            w_pos_nxt[a] = w_psum[a][POS_W] ? POS_MIN : POS_MAX;
          end else begin
            w_pos_nxt[a] = w_psum[a][POS_W-1:0];
          end
        end
        MODE_ZERO:  w_pos_nxt[a] = '0;
      endcase
      w_sat_set[a] = bus.tick & w_pos_ovf[a];
    end
  end

`ifdef POS_ACCEL_EN
  always_comb begin
    w_vel_ovf = '0;
    w_acc_go  = '0;
    for (int unsigned a = 0; a < AXES; a++) begin
      w_acc_go[a]  = bus.tick & bus.accel_en[a] & ~bus.vel_we[a];
      w_vsum[a]    = {r_vel[a][VEL_W-1], r_vel[a]}
                   + {bus.accel_in[VEL_W*a+VEL_W-1], bus.accel_in[VEL_W*a +: VEL_W]};
      w_vel_nxt[a] = w_vsum[a][VEL_W-1:0];
      if (w_vsum[a][VEL_W] != w_vsum[a][VEL_W-1]) begin
        w_vel_ovf[a] = 1'b1;
        w_vel_nxt[a] = w_vsum[a][VEL_W] ? VEL_MIN : VEL_MAX;
      end
    end
  end
`endif

  // Integration reads r_vel before this edge's write, so a coincident vel_we applies on the next tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < AXES; a++) begin
        r_pos[a] <= '0;
        r_vel[a] <= '0;
      end
      r_sat       <= '0;
      r_pos_valid <= 1'b0;
    end else begin
      r_pos_valid <= bus.tick;
      for (int unsigned a = 0; a < AXES; a++) begin
        if (bus.vel_we[a]) begin
          r_vel[a] <= bus.vel_in[VEL_W*a +: VEL_W];
`ifdef POS_ACCEL_EN
        end else if (w_acc_go[a]) begin
          r_vel[a] <= w_vel_nxt[a];
`endif
        end
        if (bus.tick) begin
          r_pos[a] <= w_pos_nxt[a];
        end
`ifdef POS_ACCEL_EN
        if (w_sat_set[a] || (w_acc_go[a] && w_vel_ovf[a])) begin
`else
        if (w_sat_set[a]) begin
`endif
          r_sat[a] <= 1'b1;
        end else if (bus.flag_clr[a]) begin
          r_sat[a] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < AXES; g++) begin : g_out
    assign bus.pos[POS_W*g +: POS_W] = r_pos[g];
    assign bus.vel[VEL_W*g +: VEL_W] = r_vel[g];
  end

  assign bus.sat_flag  = r_sat;
  assign bus.pos_valid = r_pos_valid;

endmodule

// File: tb/tb_spatial_position_integrator.sv
// Self-checking bench: directed scenarios plus randomized traffic against an integer reference model.
module tb_spatial_position_integrator;
  localparam int AXES  = 3;
  localparam int POS_W = 16;
  localparam int VEL_W = 8;
  localparam int PMAX  = 32767;
  localparam int PMIN  = -32768;
  localparam int VMAX  = 127;
  localparam int VMIN  = -128;
  localparam int HOLD = 0, LOAD = 1, INTEG = 2, ZERO = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spatial_position_integrator_if #(.AXES(AXES), .POS_W(POS_W), .VEL_W(VEL_W)) bus ();

  spatial_position_integrator #(.AXES(AXES), .POS_W(POS_W), .VEL_W(VEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int d_mode [AXES], d_load [AXES], d_vin [AXES], d_acc [AXES];
  bit d_we [AXES], d_clr [AXES], d_acc_en [AXES];
  bit d_tick;

  int m_pos [AXES], m_vel [AXES];
  bit m_sat [AXES];
  bit m_valid;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input int a);
    logic [POS_W-1:0] t;
    t = bus.pos[a*POS_W +: POS_W];
    return int'($signed(t));
  endfunction

  function automatic int vel_of(input int a);
    logic [VEL_W-1:0] t;
    t = bus.vel[a*VEL_W +: VEL_W];
    return int'($signed(t));
  endfunction

  task automatic idle();
    for (int a = 0; a < AXES; a++) begin
      d_mode[a] = HOLD; d_load[a] = 0; d_vin[a] = 0; d_acc[a] = 0;
      d_we[a] = 0; d_clr[a] = 0; d_acc_en[a] = 0;
    end
    d_tick = 0;
  endtask

  task automatic drive();
    bus.tick = d_tick;
    for (int a = 0; a < AXES; a++) begin
      bus.mode[2*a +: 2]             = 2'(d_mode[a]);
      bus.load_val[a*POS_W +: POS_W] = POS_W'(d_load[a]);
      bus.vel_in[a*VEL_W +: VEL_W]   = VEL_W'(d_vin[a]);
      bus.vel_we[a]                  = d_we[a];
      bus.flag_clr[a]                = d_clr[a];
`ifdef POS_ACCEL_EN
      bus.accel_in[a*VEL_W +: VEL_W] = VEL_W'(d_acc[a]);
      bus.accel_en[a]                = d_acc_en[a];
`endif
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi, inout bit hit);
    if (v > hi) begin hit = 1; return hi; end
    if (v < lo) begin hit = 1; return lo; end
    return v;
  endfunction

  // Next state from the behavioural rules, using the state as it was before the edge.
  function automatic void model_step();
    if (!rst_n) begin
      for (int a = 0; a < AXES; a++) begin m_pos[a] = 0; m_vel[a] = 0; m_sat[a] = 0; end
      m_valid = 0;
      return;
    end
    m_valid = d_tick;
    for (int a = 0; a < AXES; a++) begin
      int np, nv;
      bit hit;
      hit = 0; np = m_pos[a]; nv = m_vel[a];
      if (d_tick) begin
        case (d_mode[a])
          LOAD:  np = d_load[a];
          INTEG: np = clamp(m_pos[a] + m_vel[a], PMIN, PMAX, hit);
          ZERO:  np = 0;
          default: np = m_pos[a];
        endcase
      end
      if (d_we[a]) nv = d_vin[a];
`ifdef POS_ACCEL_EN
      else if (d_tick && d_acc_en[a]) nv = clamp(m_vel[a] + d_acc[a], VMIN, VMAX, hit);
`endif
      if (hit) m_sat[a] = 1;
      else if (d_clr[a]) m_sat[a] = 0;
      m_pos[a] = np; m_vel[a] = nv;
    end
  endfunction

  task automatic compare_all();
    for (int a = 0; a < AXES; a++) begin
      check($sformatf("pos[%0d]", a), pos_of(a), m_pos[a]);
      check($sformatf("vel[%0d]", a), vel_of(a), m_vel[a]);
      check($sformatf("sat_flag[%0d]", a), int'(bus.sat_flag[a]), int'(m_sat[a]));
    end
    check("pos_valid", int'(bus.pos_valid), int'(m_valid));
  endtask

  task automatic cycle();
    drive();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int exp_t2 [4] = '{253, 250, 247, 244};

    idle(); rst_n = 0; drive();

    // Reset holds everything at zero despite tick/INTEG/vel_we
    d_tick = 1;
    for (int a = 0; a < AXES; a++) begin d_mode[a] = INTEG; d_vin[a] = 5; d_we[a] = 1; end
    repeat (3) begin
      cycle();
      check("t1_rst_pos", pos_of(0), 0);
      check("t1_rst_vel", vel_of(0), 0);
      check("t1_rst_valid", int'(bus.pos_valid), 0);
    end
    rst_n = 1;
    idle(); d_we[0] = 1; d_vin[0] = 5; cycle();
    check("t1_vel", vel_of(0), 5);
    check("t1_valid_low", int'(bus.pos_valid), 0);
    idle(); d_tick = 1; d_mode[0] = INTEG; cycle();
    check("t1_pos", pos_of(0), 5);
    check("t1_valid_high", int'(bus.pos_valid), 1);

    // Load then integrate with negative velocity
    idle(); d_tick = 1; d_mode[0] = LOAD; d_load[0] = 256; cycle();
    check("t2_load", pos_of(0), 256);
    idle(); d_we[0] = 1; d_vin[0] = -3; cycle();
    check("t2_valid_idle", int'(bus.pos_valid), 0);
    idle(); d_tick = 1; d_mode[0] = INTEG;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t2_integ", pos_of(0), exp_t2[k]);
      check("t2_valid", int'(bus.pos_valid), 1);
    end

    // Saturation at both limits (0x7FF0 + 0x7F, 0x8005 + 0x80)
    idle(); d_tick = 1; d_mode[0] = LOAD; d_load[0] = 32752; d_we[0] = 1; d_vin[0] = 127; cycle();
    idle(); d_tick = 1; d_mode[0] = INTEG; cycle();
    check("t3_pos_max", pos_of(0), 32767);
    check("t3_sat", int'(bus.sat_flag[0]), 1);
    cycle();
    check("t3_pos_max_hold", pos_of(0), 32767);
    idle(); d_tick = 1; d_mode[0] = LOAD; d_load[0] = -32763; d_we[0] = 1; d_vin[0] = -128; cycle();
    idle(); d_tick = 1; d_mode[0] = INTEG; cycle();
    check("t3_pos_min", pos_of(0), -32768);

    // Clear racing a saturating tick loses; clear on HOLD wins
    idle(); d_tick = 1; d_mode[0] = INTEG; d_clr[0] = 1; cycle();
    check("t4_set_wins", int'(bus.sat_flag[0]), 1);
    idle(); d_tick = 1; d_mode[0] = HOLD; d_clr[0] = 1; cycle();
    check("t4_cleared", int'(bus.sat_flag[0]), 0);

    // Velocity write coincident with integration
    idle(); d_tick = 1; d_mode[0] = LOAD; d_load[0] = 10; d_we[0] = 1; d_vin[0] = 2; cycle();
    idle(); d_tick = 1; d_mode[0] = INTEG; d_we[0] = 1; d_vin[0] = 7; cycle();
    check("t5_pos_old_vel", pos_of(0), 12);
    check("t5_vel_new", vel_of(0), 7);
    idle(); d_tick = 1; d_mode[0] = INTEG; cycle();
    check("t5_pos_new_vel", pos_of(0), 19);

    // Per-axis independence
    idle(); d_tick = 1;
    for (int a = 0; a < AXES; a++) begin d_mode[a] = LOAD; d_load[a] = 50; d_we[a] = 1; d_vin[a] = 1; end
    cycle();
    idle(); d_tick = 1; d_mode[0] = HOLD; d_mode[1] = ZERO; d_mode[2] = INTEG; cycle();
    check("t6_hold", pos_of(0), 50);
    check("t6_zero", pos_of(1), 0);
    check("t6_integ", pos_of(2), 51);
`ifdef POS_ACCEL_EN
    idle(); d_tick = 1; d_mode[2] = LOAD; d_load[2] = 50; cycle();
    idle(); d_tick = 1; d_mode[2] = INTEG; d_acc[2] = 2; d_acc_en[2] = 1;
    cycle();
    check("t6_acc_pos1", pos_of(2), 51);
    check("t6_acc_vel1", vel_of(2), 3);
    cycle();
    check("t6_acc_pos2", pos_of(2), 54);
    check("t6_acc_vel2", vel_of(2), 5);
`endif

    // Randomized traffic, values biased toward the limits
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      d_tick = ($urandom_range(0, 3) != 0);
      for (int a = 0; a < AXES; a++) begin
        d_mode[a] = $urandom_range(0, 3);
        if (d_mode[a] == ZERO && $urandom_range(0, 3) != 0) d_mode[a] = INTEG;
        case ($urandom_range(0, 2))
          0: d_load[a] = PMAX - int'($urandom_range(0, 300));
          1: d_load[a] = PMIN + int'($urandom_range(0, 300));
          default: d_load[a] = int'($signed(16'($urandom)));
        endcase
        d_vin[a]    = int'($signed(8'($urandom)));
        d_we[a]     = ($urandom_range(0, 4) == 0);
        d_clr[a]    = ($urandom_range(0, 7) == 0);
        d_acc[a]    = int'($signed(8'($urandom)));
        d_acc_en[a] = ($urandom_range(0, 1) == 0);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
